// File: rtl/fp16_pkg.sv
// Shared constants, state encoding and field indices for the FP16 normalise/round stage.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int MANT_W  = 10;
  localparam int M_W     = MANT_W + 2;   // carry, hidden, fraction
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] INF  = 16'h7C00;

  // Bit positions inside the 3-bit guard/round/sticky bundle
  localparam int GRS_G = 2;
  localparam int GRS_R = 1;
  localparam int GRS_S = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_NORM,
    S_ROUND,
    S_DONE
  } nr_state_t;

endpackage

// File: rtl/fp16_lzc.sv
// Combinational 12-bit leading-zero counter; all-zero input reports 12.
module fp16_lzc (
  input  logic [11:0] din,
  output logic [3:0]  count
);

  // Highest set bit wins because it is visited last
  always_comb begin
    count = 4'd12;
    for (int i = 0; i < 12; i++) begin
      if (din[i]) count = 4'(11 - i);
    end
  end

endmodule

// File: rtl/fp16_norm_round.sv
// FP16 adder normalise / round-to-nearest-even / pack stage with valid/ready handshake.
// Optional build macro FP16_NR_LZC_EN: normalisation completes in a single NORM cycle
// using fp16_lzc instead of one left shift per cycle. Results are identical either way.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// CHECK | zero detect, carry right-shift, or decide whether normalisation is needed
// NORM  | left-normalise toward the hidden bit, never below exponent 1
// ROUND | round to nearest even, detect overflow, pack result
// DONE  | result held until out_ready
module fp16_norm_round
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [M_W-1:0]    in_mant,
  input  logic [2:0]        in_grs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              busy
);

  nr_state_t state, state_nxt;

  // Exponent carries one extra bit so carry/round increments past 31 stay visible
  logic           sign_q;
  logic [5:0]     exp_q;
  logic [M_W-1:0] mant_q;
  logic           g_q, r_q, s_q;

  logic           is_zero;
  logic [M_W-1:0] norm_mant;
  logic [5:0]     norm_exp;
  logic           norm_g, norm_r, norm_last;
  logic           rnd_inc;
  logic [M_W-1:0] rnd_sum, rnd_mant;
  logic [5:0]     rnd_exp;
  logic           rnd_ovf, rnd_unf;

  assign is_zero = (mant_q == '0) && !(g_q | r_q | s_q);

`ifdef FP16_NR_LZC_EN
  logic [3:0]  lzc;
  logic [5:0]  shamt;
  logic [12:0] w_sh;

  fp16_lzc u_lzc (
    .din   ({mant_q[10:0], g_q}),
    .count (lzc)
  );

  // Whole normalisation in one step, clamped so the exponent floors at 1
  always_comb begin
    shamt     = ({2'b00, lzc} < (exp_q - 6'd1)) ? {2'b00, lzc} : (exp_q - 6'd1);
    w_sh      = {mant_q[10:0], g_q, r_q} << shamt;
    norm_mant = {1'b0, w_sh[12:2]};
    norm_g    = w_sh[1];
    norm_r    = w_sh[0];
    norm_exp  = exp_q - shamt;
    norm_last = 1'b1;
  end
`else
  // One left shift per cycle; at the exponent floor leave the operand untouched
  always_comb begin
    norm_mant = mant_q;
    norm_g    = g_q;
    norm_r    = r_q;
    norm_exp  = exp_q;
    norm_last = 1'b1;
    if (exp_q > 6'd1) begin
      norm_mant = {mant_q[10:0], g_q};
      norm_g    = r_q;
      norm_r    = 1'b0;
      norm_exp  = exp_q - 6'd1;
      norm_last = norm_mant[10] | (norm_exp == 6'd1);
    end
  end
`endif

  // Round to nearest even; a carry out of the hidden bit renormalises by one
  always_comb begin
    rnd_inc  = g_q & (r_q | s_q | mant_q[0]);
    rnd_sum  = mant_q + {{(M_W-1){1'b0}}, rnd_inc};
    rnd_mant = rnd_sum[11] ? {1'b0, rnd_sum[11:1]} : rnd_sum;
    rnd_exp  = exp_q + {5'b0, rnd_sum[11]};
    rnd_ovf  = (rnd_exp >= 6'(EXP_MAX));
    rnd_unf  = !rnd_ovf && !rnd_mant[10] && (g_q | r_q | s_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (is_zero)                     state_nxt = S_DONE;
        else if (mant_q[11] | mant_q[10]) state_nxt = S_ROUND;
        else                             state_nxt = S_NORM;
      end
      S_NORM:  if (norm_last) state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand datapath and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q        <= 1'b0;
      exp_q         <= 6'd0;
      mant_q        <= '0;
      g_q           <= 1'b0;
      r_q           <= 1'b0;
      s_q           <= 1'b0;
      out_result    <= 16'h0000;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          sign_q <= in_sign;
          exp_q  <= (in_exp == '0) ? 6'd1 : {1'b0, in_exp};
          mant_q <= in_mant;
          g_q    <= in_grs[GRS_G];
          r_q    <= in_grs[GRS_R];
          s_q    <= in_grs[GRS_S];
        end
        S_CHECK: begin
          if (is_zero) begin
            out_result    <= {sign_q, 15'b0};
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
          end else if (mant_q[11]) begin
            mant_q <= {1'b0, mant_q[11:1]};
            exp_q  <= exp_q + 6'd1;
            g_q    <= mant_q[0];
            r_q    <= g_q;
            s_q    <= r_q | s_q;
          end
        end
        S_NORM: begin
          mant_q <= norm_mant;
          exp_q  <= norm_exp;
          g_q    <= norm_g;
          r_q    <= norm_r;
        end
        S_ROUND: begin
          if (rnd_ovf) out_result <= {sign_q, INF[14:0]};
          else         out_result <= {sign_q, (rnd_mant[10] ? rnd_exp[4:0] : 5'd0), rnd_mant[9:0]};
          out_overflow  <= rnd_ovf;
          out_underflow <= rnd_unf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_norm_round.sv
// Self-checking bench for fp16_norm_round: integer-arithmetic reference model, scoreboard
// queue checked every cycle out_valid is high, directed plan vectors and random traffic.
module tb_fp16_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [4:0]  in_exp = '0;
  logic [11:0] in_mant = '0;
  logic [2:0]  in_grs = '0;
  logic        out_valid;
  wire         out_ready;
  logic [15:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        busy;

  logic ready_fixed = 1'b1;
  logic rand_ready  = 1'b0;
  logic rnd_ready   = 1'b1;
  assign out_ready = rand_ready ? rnd_ready : ready_fixed;

  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] expq[$];   // {result, overflow, underflow}

  fp16_norm_round dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_underflow(out_underflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef FP16_NR_LZC_EN
  localparam int LAT_NORM3 = 4;
`else
  localparam int LAT_NORM3 = 6;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout", name);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Significand as one integer: [13]=carry [12]=hidden [11:2]=fraction [1]=guard [0]=round,
  // sticky kept aside; the left shifts never move sticky.
  function automatic logic [17:0] model(input logic s, input logic [4:0] e_in,
                                        input logic [11:0] m, input logic [2:0] grs);
    int e, sig, keep, ef;
    bit sticky, g, rest, inexact;
    e = (e_in == 0) ? 1 : int'(e_in);
    if (m == 0 && grs == 0) return {s, 15'b0, 2'b00};
    sig    = int'(m) * 4 + int'(grs[2:1]);
    sticky = grs[0];
    if (sig >= 8192) begin
      sticky = sticky | (sig % 2 == 1);
      sig = sig / 2;
      e++;
    end
    while (sig < 4096 && e > 1) begin
      sig = sig * 2;
      e--;
    end
    keep    = sig / 4;
    g       = ((sig / 2) % 2) == 1;
    rest    = ((sig % 2) == 1) || sticky;
    inexact = g || rest;
    if (g && (rest || (keep % 2 == 1))) keep++;
    if (keep >= 2048) begin
      keep = keep / 2;
      e++;
    end
    if (e >= 31) return {s, 5'h1F, 10'h000, 2'b10};
    ef = (keep >= 1024) ? e : 0;
    return {s, 5'(ef), 10'(keep % 1024), 1'b0, (ef == 0) && inexact};
  endfunction

  // Presents one operand and returns one cycle after the accept edge
  task automatic send(input logic s, input logic [4:0] e, input logic [11:0] m, input logic [2:0] g);
    int t;
    t = 0;
    while (!in_ready) begin
      @(posedge clk); #1;
      t++;
      if (t > 200) abort("wait_in_ready");
    end
    in_sign = s; in_exp = e; in_mant = m; in_grs = g;
    in_valid = 1'b1;
    expq.push_back(model(s, e, m, g));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts the accept edge as cycle 1
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid) begin
      @(posedge clk); #1;
      lat++;
      if (lat > 50) abort("wait_out_valid");
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy || expq.size() != 0) begin
      @(posedge clk); #1;
      t++;
      if (t > 200) abort("wait_idle");
    end
  endtask

  // Scoreboard: every cycle the result is offered it must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got result %0h with nothing outstanding", out_result);
        end else begin
          check("out_result", 32'(out_result), 32'(expq[0][17:2]));
          check("out_overflow", 32'(out_overflow), 32'(expq[0][1]));
          check("out_underflow", 32'(out_underflow), 32'(expq[0][0]));
          check("in_ready_in_done", 32'(in_ready), 32'd0);
          if (out_ready) void'(expq.pop_front());
        end
      end
    end
  end

  // Random backpressure when enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int lat;
    logic [4:0]  re;
    logic [11:0] rm;

    // Model pinned against hand-computed vectors
    check("model_basic",    32'(model(0, 15, 12'h400, 3'b000)), {14'd0, 16'h3C00, 2'b00});
    check("model_carry",    32'(model(0, 15, 12'hC00, 3'b000)), {14'd0, 16'h4200, 2'b00});
    check("model_norm3",    32'(model(0, 15, 12'h080, 3'b000)), {14'd0, 16'h3000, 2'b00});
    check("model_tie_odd",  32'(model(0, 15, 12'h401, 3'b100)), {14'd0, 16'h3C02, 2'b00});
    check("model_tie_even", 32'(model(0, 15, 12'h400, 3'b100)), {14'd0, 16'h3C00, 2'b00});
    check("model_rnd_carry",32'(model(0, 15, 12'h7FF, 3'b110)), {14'd0, 16'h4000, 2'b00});
    check("model_ovf",      32'(model(1, 30, 12'hFFF, 3'b111)), {14'd0, 16'hFC00, 2'b10});
    check("model_zero",     32'(model(1, 15, 12'h000, 3'b000)), {14'd0, 16'h8000, 2'b00});
    check("model_unf",      32'(model(0, 1,  12'h010, 3'b001)), {14'd0, 16'h0010, 2'b01});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'h0000);
    check("rst_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed plan vectors with latency checks
    send(0, 15, 12'h400, 3'b000); wait_valid(lat); check("lat_basic", lat, 3); wait_idle();
    send(0, 15, 12'hC00, 3'b000); wait_valid(lat); check("lat_carry", lat, 3); wait_idle();
    send(0, 15, 12'h080, 3'b000); wait_valid(lat); check("lat_norm3", lat, LAT_NORM3); wait_idle();
    send(0, 15, 12'h401, 3'b100); wait_idle();
    send(0, 15, 12'h400, 3'b100); wait_idle();
    send(0, 15, 12'h7FF, 3'b110); wait_idle();
    send(1, 30, 12'hFFF, 3'b111); wait_idle();
    send(1, 15, 12'h000, 3'b000); wait_idle();
    send(0, 1,  12'h010, 3'b001); wait_idle();
    send(0, 0,  12'h3FF, 3'b110); wait_idle();
    send(0, 31, 12'h400, 3'b000); wait_idle();

    // Backpressure: result held with out_ready low
    ready_fixed = 1'b0;
    send(0, 15, 12'h400, 3'b000);
    wait_valid(lat);
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(out_result), 32'h3C00);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    ready_fixed = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a long normalisation
    send(0, 15, 12'h001, 3'b000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    expq.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("midrst_no_output", 32'(out_valid), 32'd0);

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      re = 5'($urandom_range(0, 31));
      rm = 12'($urandom) & (12'hFFF >> $urandom_range(0, 11));
      send(1'($urandom), re, rm, 3'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
